// File: rtl/stepper_pkg.sv
// Shared types and helpers for the step/direction pulse generator.
package stepper_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_e;

  // The period must leave at least one low cycle after the high time.
  function automatic logic [31:0] eff_period(input logic [31:0] cfg, input logic [31:0] hi);
    return (cfg > hi + 32'd1) ? cfg : hi + 32'd1;
  endfunction

endpackage

// File: rtl/stepper_phase_timer.sv
// Loadable down-counter that times one FSM phase; saturates at zero.
module stepper_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/stepper_pulse_gen.sv
// Step/direction pulse generator for one axis: command FSM, step count, position.
module stepper_pulse_gen
  import stepper_pkg::*;
#(
  parameter int POS_W     = 16,
  parameter int CNT_W     = 16,
  parameter int PER_W     = 16,
  parameter int HI_CYC    = 4,
  parameter int DIR_SETUP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             abort,
  input  logic [PER_W-1:0] cfg_period,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             pos_load,
  input  logic [POS_W-1:0] pos_load_val,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [POS_W-1:0] position,
  output logic [7:0]       led
);

  state_e           state, state_nx;
  logic [CNT_W-1:0] rem;
  logic [PER_W-1:0] per_q;
  logic             abort_req;
  logic             tmr_load, tmr_zero;
  logic [PER_W-1:0] tmr_val;
  logic             done_nx, abrt_nx;
  logic             rise;

  stepper_phase_timer #(.W(PER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (busy),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Timer is loaded with (duration-1) on every phase entry.
  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    done_nx  = 1'b0;
    abrt_nx  = 1'b0;
    unique case (state)
      IDLE: if (cmd_valid) begin
        tmr_load = 1'b1;
        if (cmd_steps == '0) state_nx = LOW;  // one LOW cycle with nothing left -> done
        else begin
          state_nx = SETUP;
          tmr_val  = PER_W'(DIR_SETUP - 1);
        end
      end
      SETUP: if (abort_req) begin
        state_nx = IDLE; done_nx = 1'b1; abrt_nx = 1'b1;
      end else if (tmr_zero && en) begin
        state_nx = HIGH; tmr_load = 1'b1; tmr_val = PER_W'(HI_CYC - 1);
      end
      HIGH: if (tmr_zero) begin
        if (abort_req) begin
          state_nx = IDLE; done_nx = 1'b1; abrt_nx = 1'b1;
        end else begin
          state_nx = LOW; tmr_load = 1'b1;
          tmr_val  = per_q - PER_W'(HI_CYC) - PER_W'(1);
        end
      end
      LOW: if (abort_req) begin
        state_nx = IDLE; done_nx = 1'b1; abrt_nx = 1'b1;
      end else if (tmr_zero) begin
        if (rem == '0) begin
          state_nx = IDLE; done_nx = 1'b1;
        end else if (en) begin
          state_nx = HIGH; tmr_load = 1'b1; tmr_val = PER_W'(HI_CYC - 1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rise = (state_nx == HIGH) && (state != HIGH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= 1'b0;
      dir       <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      rem       <= '0;
      per_q     <= '0;
      abort_req <= 1'b0;
      position  <= '0;
    end else begin
      state   <= state_nx;
      step    <= (state_nx == HIGH);
      done    <= done_nx;
      aborted <= abrt_nx;
      if (state == IDLE && cmd_valid) begin
        dir   <= cmd_dir;
        rem   <= cmd_steps;
        per_q <= PER_W'(eff_period(32'(cfg_period), 32'(HI_CYC)));
      end else if (rise) begin
        rem <= rem - 1'b1;
      end
      // Abort is registered, so a sampled abort takes effect one edge later.
      if (state_nx == IDLE)            abort_req <= 1'b0;
      else if (abort && state != IDLE) abort_req <= 1'b1;
      if (state == IDLE && pos_load) position <= pos_load_val;
      else if (rise)                 position <= dir ? position + 1'b1 : position - 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE);
  assign led       = position[7:0];

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Directed bench for stepper_pulse_gen; expected edges are hand-derived from the timing rules.
module tb_stepper_pulse_gen;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        en = 1'b1, abort = 1'b0;
  logic [15:0] cfg_period = 16'd10;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic        pos_load = 1'b0;
  logic [15:0] pos_load_val = '0;
  logic        step, dir, busy, done, aborted;
  logic [15:0] position;
  logic [7:0]  led;

  stepper_pulse_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .abort(abort), .cfg_period(cfg_period),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
    .pos_load(pos_load), .pos_load_val(pos_load_val), .step(step), .dir(dir), .busy(busy),
    .done(done), .aborted(aborted), .position(position), .led(led)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, hcnt = 0;
  logic prev = 1'b0;
  int rise_q[$], pos_q[$], hi_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, record rises and high widths.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (step && !prev) begin rise_q.push_back(cyc); pos_q.push_back(int'(position)); end
    if (step) hcnt++;
    else if (prev) begin hi_q.push_back(hcnt); hcnt = 0; end
    prev = step;
  endtask

  task automatic clear_q();
    rise_q.delete(); pos_q.delete(); hi_q.delete();
  endtask

  task automatic send(input logic d, input logic [15:0] n, input logic [15:0] per, output int k);
    cmd_valid = 1'b1; cmd_dir = d; cmd_steps = n; cfg_period = per;
    tick();
    cmd_valid = 1'b0;
    k = cyc;
  endtask

  task automatic wait_done(input int lim, output int dc, output logic ab);
    dc = -1; ab = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (done) begin dc = cyc; ab = aborted; break; end
    end
  endtask

  initial begin
    int k, k2, dc;
    logic ab;

    repeat (3) tick();
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_pos", position, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_ready", cmd_ready, 1);

    // Basic 3-step forward move, period 10.
    clear_q();
    send(1'b1, 16'd3, 16'd10, k);
    chk("t1_dir", dir, 1);
    chk("t1_busy", busy, 1);
    wait_done(100, dc, ab);
    chk("t1_nrise", rise_q.size(), 3);
    chk("t1_rise0", rise_q[0], k + 2);
    chk("t1_rise1", rise_q[1], k + 12);
    chk("t1_rise2", rise_q[2], k + 22);
    chk("t1_hi0", hi_q[0], 4);
    chk("t1_hi2", hi_q[2], 4);
    chk("t1_done", dc, k + 32);
    chk("t1_abrt", ab, 0);
    chk("t1_pos", position, 3);
    chk("t1_ready", cmd_ready, 1);

    // Period below minimum clamps to HI_CYC+1 = 5.
    clear_q();
    send(1'b1, 16'd2, 16'd2, k);
    wait_done(100, dc, ab);
    chk("t2_rise0", rise_q[0], k + 2);
    chk("t2_rise1", rise_q[1], k + 7);
    chk("t2_hi0", hi_q[0], 4);
    chk("t2_hi1", hi_q[1], 4);
    chk("t2_done", dc, k + 12);
    chk("t2_pos", position, 5);

    // Position wrap in both directions, back-to-back moves.
    pos_load = 1'b1; pos_load_val = 16'hFFFF;
    tick();
    pos_load = 1'b0;
    chk("t3_load", position, 16'hFFFF);
    clear_q();
    send(1'b1, 16'd2, 16'd10, k);
    wait_done(100, dc, ab);
    chk("t3_fpos0", pos_q[0], 16'h0000);
    chk("t3_fpos1", pos_q[1], 16'h0001);
    clear_q();
    send(1'b0, 16'd2, 16'd10, k2);
    chk("t3_b2b", k2, dc + 1);
    chk("t3_dir", dir, 0);
    wait_done(100, dc, ab);
    chk("t3_brise0", rise_q[0], k2 + 2);
    chk("t3_bpos0", pos_q[0], 16'h0000);
    chk("t3_bpos1", pos_q[1], 16'hFFFF);
    chk("t3_led", led, 8'hFF);

    // Abort during the second HIGH phase.
    pos_load = 1'b1; pos_load_val = 16'h0000;
    tick();
    pos_load = 1'b0;
    clear_q();
    send(1'b1, 16'd5, 16'd10, k);
    while (cyc < k + 13) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(100, dc, ab);
    chk("t4_done", dc, k + 16);
    chk("t4_abrt", ab, 1);
    chk("t4_hi1", hi_q[1], 4);
    chk("t4_pos", position, 2);
    repeat (20) tick();
    chk("t4_nrise", rise_q.size(), 2);

    // en low through a LOW phase for 20 cycles.
    clear_q();
    send(1'b1, 16'd5, 16'd10, k);
    while (cyc < k + 7) tick();
    en = 1'b0;
    repeat (20) tick();
    en = 1'b1;
    wait_done(200, dc, ab);
    chk("t5_nrise", rise_q.size(), 5);
    chk("t5_rise1", rise_q[1], k + 28);
    chk("t5_rise4", rise_q[4], k + 58);
    chk("t5_done", dc, k + 68);
    chk("t5_pos", position, 7);

    // Zero-step command: done next edge, dir still updates.
    clear_q();
    send(1'b0, 16'd0, 16'd10, k);
    chk("t6_dir", dir, 0);
    wait_done(20, dc, ab);
    chk("t6_done", dc, k + 1);
    chk("t6_abrt", ab, 0);
    chk("t6_nrise", rise_q.size(), 0);
    chk("t6_pos", position, 7);

    // Asynchronous reset in the middle of a HIGH phase.
    send(1'b1, 16'd3, 16'd10, k);
    while (!step && cyc < k + 10) tick();
    chk("t7_high", step, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_step", step, 0);
    chk("t7_busy", busy, 0);
    chk("t7_pos", position, 0);
    chk("t7_dir", dir, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("t7_ready", cmd_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
